// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_TGT,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_WRITE,
    ST_RUN,
    ST_ERR
  } state_e;

  // Section target codes carried in the first byte of every section.
  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_DMEM = 8'h01;
  localparam logic [7:0] TGT_END  = 8'hFF;

  // External memory address for a word index: byte address (x4) or word address.
  function automatic logic [31:0] ext_addr(input logic [15:0] idx, input bit byte_addr);
    return byte_addr ? {14'd0, idx, 2'b00} : {16'd0, idx};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Stream input, memory write ports and status of the program loader.
interface prog_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] addr_ext;
  logic [31:0] wdata_ext;
  logic        wen_ext;
  logic [31:0] addr_ext_2;
  logic [31:0] wdata_ext_2;
  logic        wen_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        err;

  // Upstream side: produces the byte stream and observes the loader.
  modport master (
    output in_valid, in_data,
    input  in_ready, addr_ext, wdata_ext, wen_ext,
    input  addr_ext_2, wdata_ext_2, wen_ext_2, cpu_enable, busy, err
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, addr_ext, wdata_ext, wen_ext,
    output addr_ext_2, wdata_ext_2, wen_ext_2, cpu_enable, busy, err
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Little-endian word assembly: byte lanes filled in order 0..3.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [31:0] lanes_q, lanes_d;
  logic [1:0]  byte_idx_q, byte_idx_d;

  // Next lane contents and lane pointer; clear discards any partial word.
  always_comb begin
    lanes_d    = lanes_q;
    byte_idx_d = byte_idx_q;
    if (clear) begin
      lanes_d    = '0;
      byte_idx_d = '0;
    end else if (byte_en) begin
      lanes_d[{byte_idx_q, 3'b000} +: 8] = byte_in;
      byte_idx_d = byte_idx_q + 2'd1;
    end
  end

  // The completed word includes the byte arriving this cycle.
  assign word      = lanes_d;
  assign word_done = byte_en && !clear && (byte_idx_q == 2'd3);

  // Lane and pointer registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lanes_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      byte_idx_q <= byte_idx_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing CPU instruction/data memories, then enabling the CPU.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 512,
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter bit          BYTE_ADDR  = 1'b1
) (
  input logic         clk,
  input logic         arst_n,
  prog_loader_if.slave bus
);

  state_e      state_q, state_d;
  logic        tgt_dmem_q, tgt_dmem_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic        wen_q, wen_d;
  logic        wen2_q, wen2_d;
  logic [31:0] addr_q, addr_d, addr2_q, addr2_d;
  logic [31:0] wdata_q, wdata_d, wdata2_q, wdata2_d;

  logic        hs;
  logic [15:0] n_full;
  logic [31:0] depth;
  logic        asm_clear, asm_en, word_done;
  logic [31:0] word;
  logic [15:0] idx_inc;

  assign hs      = bus.in_valid && in_ready_q;
  assign n_full  = {bus.in_data, cnt_lo_q};
  assign depth   = tgt_dmem_q ? 32'(DMEM_DEPTH) : 32'(IMEM_DEPTH);
  assign idx_inc = word_idx_q + 16'd1;
  assign asm_en  = hs && (state_q == ST_DATA);

  word_assembler u_asm (
    .clk       (clk),
    .arst_n    (arst_n),
    .clear     (asm_clear),
    .byte_en   (asm_en),
    .byte_in   (bus.in_data),
    .word      (word),
    .word_done (word_done)
  );

  // Next-state, counter and registered-output logic of the framing FSM.
  always_comb begin
    state_d    = state_q;
    tgt_dmem_d = tgt_dmem_q;
    cnt_lo_d   = cnt_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    wen_d      = 1'b0;
    wen2_d     = 1'b0;
    addr_d     = addr_q;
    addr2_d    = addr2_q;
    wdata_d    = wdata_q;
    wdata2_d   = wdata2_q;
    asm_clear  = 1'b0;

    case (state_q)
      ST_TGT: if (hs) begin
        case (bus.in_data)
          TGT_IMEM: begin tgt_dmem_d = 1'b0; state_d = ST_CNT_LO; end
          TGT_DMEM: begin tgt_dmem_d = 1'b1; state_d = ST_CNT_LO; end
          TGT_END:  state_d = ST_RUN;
          default:  state_d = ST_ERR;
        endcase
      end
      ST_CNT_LO: if (hs) begin
        cnt_lo_d = bus.in_data;
        state_d  = ST_CNT_HI;
      end
      ST_CNT_HI: if (hs) begin
        if (n_full == 16'd0) begin
          state_d = ST_TGT;
        end else if ({16'd0, n_full} > depth) begin
          state_d = ST_ERR;
        end else begin
          count_d    = n_full;
          word_idx_d = '0;
          asm_clear  = 1'b1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: if (word_done) begin
        state_d = ST_WRITE;
        if (tgt_dmem_q) begin
          wen2_d   = 1'b1;
          addr2_d  = ext_addr(word_idx_q, BYTE_ADDR);
          wdata2_d = word;
        end else begin
          wen_d   = 1'b1;
          addr_d  = ext_addr(word_idx_q, BYTE_ADDR);
          wdata_d = word;
        end
      end
      ST_WRITE: begin
        word_idx_d = idx_inc;
        state_d    = (idx_inc == count_q) ? ST_TGT : ST_DATA;
      end
      default: state_d = state_q;  // RUN and ERR hold until reset
    endcase

    in_ready_d   = (state_d == ST_TGT) || (state_d == ST_CNT_LO) ||
                   (state_d == ST_CNT_HI) || (state_d == ST_DATA);
    busy_d       = (state_d == ST_CNT_LO) || (state_d == ST_CNT_HI) ||
                   (state_d == ST_DATA) || (state_d == ST_WRITE);
    err_d        = (state_d == ST_ERR);
    cpu_enable_d = (state_d == ST_RUN);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_TGT;
      tgt_dmem_q   <= 1'b0;
      cnt_lo_q     <= '0;
      count_q      <= '0;
      word_idx_q   <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_enable_q <= 1'b0;
      wen_q        <= 1'b0;
      wen2_q       <= 1'b0;
      addr_q       <= '0;
      addr2_q      <= '0;
      wdata_q      <= '0;
      wdata2_q     <= '0;
    end else begin
      state_q      <= state_d;
      tgt_dmem_q   <= tgt_dmem_d;
      cnt_lo_q     <= cnt_lo_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      cpu_enable_q <= cpu_enable_d;
      wen_q        <= wen_d;
      wen2_q       <= wen2_d;
      addr_q       <= addr_d;
      addr2_q      <= addr2_d;
      wdata_q      <= wdata_d;
      wdata2_q     <= wdata2_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.cpu_enable  = cpu_enable_q;
  assign bus.wen_ext     = wen_q;
  assign bus.addr_ext    = addr_q;
  assign bus.wdata_ext   = wdata_q;
  assign bus.wen_ext_2   = wen2_q;
  assign bus.addr_ext_2  = addr2_q;
  assign bus.wdata_ext_2 = wdata2_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: two instances (byte and word addressing) fed the same stream.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       drv_valid = 1'b0;
  logic [7:0] drv_data = 8'h00;

  always #5 clk = ~clk;

  prog_loader_if ifa ();
  prog_loader_if ifb ();

  assign ifa.in_valid = drv_valid;
  assign ifa.in_data  = drv_data;
  assign ifb.in_valid = drv_valid;
  assign ifb.in_data  = drv_data;

  prog_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024), .BYTE_ADDR(1'b1)) dut_a (
    .clk(clk), .arst_n(arst_n), .bus(ifa.slave));
  prog_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024), .BYTE_ADDR(1'b0)) dut_b (
    .clk(clk), .arst_n(arst_n), .bus(ifb.slave));

  typedef struct packed {
    logic        port;   // 0 = instruction memory, 1 = data memory
    logic [15:0] idx;
    logic [31:0] data;
  } wr_t;

  wr_t        qa[$];
  wr_t        qb[$];
  logic [7:0] stim[$];
  bit         exp_run, exp_err;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: parse the frame and list the writes it should produce.
  task automatic model();
    int p = 0;
    int n;
    int t;
    logic [31:0] d;
    wr_t e;
    exp_run = 0;
    exp_err = 0;
    while (p < stim.size()) begin
      t = int'(stim[p]);
      p++;
      if (t == 255) begin exp_run = 1; break; end
      if (t > 1) begin exp_err = 1; break; end
      n = int'(stim[p]) + 256 * int'(stim[p+1]);
      p += 2;
      if (n > ((t == 1) ? 1024 : 512)) begin exp_err = 1; break; end
      for (int w = 0; w < n; w++) begin
        d = {stim[p+3], stim[p+2], stim[p+1], stim[p]};
        p += 4;
        e.port = (t == 1);
        e.idx  = 16'(w);
        e.data = d;
        qa.push_back(e);
        qb.push_back(e);
      end
    end
  endtask

  task automatic cmp_wr(input string pfx, input logic port, input logic [31:0] addr,
                        input logic [31:0] data, input logic rdy, input logic bsy,
                        input wr_t e, input int shift);
    chk({pfx, "_port"}, 32'(port), 32'(e.port));
    chk({pfx, "_addr"}, addr, 32'(e.idx) << shift);
    chk({pfx, "_data"}, data, e.data);
    chk({pfx, "_rdy_in_write"}, 32'(rdy), 32'd0);
    chk({pfx, "_busy_in_write"}, 32'(bsy), 32'd1);
  endtask

  // Write monitor, byte-addressed instance.
  always @(negedge clk) begin : mon_a
    wr_t e;
    chk("a_dual_wen", 32'(ifa.wen_ext & ifa.wen_ext_2), 32'd0);
    chk("ab_ready_agree", 32'(ifb.in_ready), 32'(ifa.in_ready));
    if (ifa.wen_ext | ifa.wen_ext_2) begin
      chk("a_wr_expected", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp_wr("a", ifa.wen_ext_2, ifa.wen_ext_2 ? ifa.addr_ext_2 : ifa.addr_ext,
               ifa.wen_ext_2 ? ifa.wdata_ext_2 : ifa.wdata_ext, ifa.in_ready, ifa.busy, e, 2);
      end
    end
  end

  // Write monitor, word-addressed instance.
  always @(negedge clk) begin : mon_b
    wr_t e;
    chk("b_dual_wen", 32'(ifb.wen_ext & ifb.wen_ext_2), 32'd0);
    if (ifb.wen_ext | ifb.wen_ext_2) begin
      chk("b_wr_expected", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp_wr("b", ifb.wen_ext_2, ifb.wen_ext_2 ? ifb.addr_ext_2 : ifb.addr_ext,
               ifb.wen_ext_2 ? ifb.wdata_ext_2 : ifb.wdata_ext, ifb.in_ready, ifb.busy, e, 0);
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_rdy"},   32'(ifa.in_ready & ifb.in_ready), 32'd1);
    chk({tag, "_wen"},   32'({ifa.wen_ext, ifa.wen_ext_2, ifb.wen_ext, ifb.wen_ext_2}), 32'd0);
    chk({tag, "_addr"},  ifa.addr_ext | ifa.addr_ext_2 | ifb.addr_ext | ifb.addr_ext_2, 32'd0);
    chk({tag, "_wdata"}, ifa.wdata_ext | ifa.wdata_ext_2 | ifb.wdata_ext | ifb.wdata_ext_2, 32'd0);
    chk({tag, "_en"},    32'(ifa.cpu_enable | ifb.cpu_enable), 32'd0);
    chk({tag, "_busy"},  32'(ifa.busy | ifb.busy), 32'd0);
    chk({tag, "_err"},   32'(ifa.err | ifb.err), 32'd0);
  endtask

  task automatic reset_dut(input string tag);
    drv_valid = 1'b0;
    arst_n = 1'b0;
    #1;
    check_reset(tag);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offer one byte, optionally after random idle cycles; returns just after its handshake.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int c = 0;
    int g = 0;
    while (gap_pct > 0 && g < 4 && $urandom_range(99) < gap_pct) begin
      drv_valid = 1'b0;
      drv_data  = 8'($urandom);
      @(negedge clk);
      g++;
    end
    drv_valid = 1'b1;
    drv_data  = b;
    while (!ifa.in_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("hs_timeout", 32'(ifa.in_ready), 32'd1);
    @(negedge clk);
    drv_valid = 1'b0;
    drv_data  = 8'($urandom);
  endtask

  task automatic run_stream(input string tag, input int gap_pct);
    qa.delete();
    qb.delete();
    model();
    for (int i = 0; i < stim.size(); i++) begin
      if (i == stim.size() - 1) chk({tag, "_en_before_end"}, 32'(ifa.cpu_enable), 32'd0);
      send_byte(stim[i], gap_pct);
    end
    chk({tag, "_en_after_end"}, 32'(ifa.cpu_enable & ifb.cpu_enable), 32'(exp_run));
    repeat (3) @(negedge clk);
    chk({tag, "_pend_a"}, 32'(qa.size()), 32'd0);
    chk({tag, "_pend_b"}, 32'(qb.size()), 32'd0);
    chk({tag, "_err"},    32'({ifa.err, ifb.err}), exp_err ? 32'd3 : 32'd0);
    chk({tag, "_en"},     32'({ifa.cpu_enable, ifb.cpu_enable}), exp_run ? 32'd3 : 32'd0);
    chk({tag, "_rdy_end"}, 32'(ifa.in_ready | ifb.in_ready), 32'd0);
    chk({tag, "_busy_end"}, 32'(ifa.busy | ifb.busy), 32'd0);
    $display("stream %s: %0d bytes, run=%0d err=%0d, errors so far=%0d",
             tag, stim.size(), exp_run, exp_err, n_err);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nsec, n;
    logic [7:0] t;
    repeat (3) @(negedge clk);
    check_reset("por");
    arst_n = 1'b1;
    @(negedge clk);

    stim = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF};
    run_stream("imem", 0);
    reset_dut("rst1");

    stim = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
    run_stream("dmem", 0);
    reset_dut("rst2");

    stim = '{8'h00, 8'h00, 8'h00, 8'hFF};
    run_stream("zero_cnt", 0);
    reset_dut("rst3");

    stim = '{8'h05};
    run_stream("bad_tgt", 0);
    reset_dut("rst4");

    stim = '{8'h00, 8'h01, 8'h02};
    run_stream("imem_ovf", 0);
    reset_dut("rst5");

    stim = '{8'h01, 8'h01, 8'h04};
    run_stream("dmem_ovf", 0);
    reset_dut("rst6");

    stim = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF};
    run_stream("imem_gaps", 40);
    reset_dut("rst7");

    // Full instruction memory: 512 words, last address at the boundary.
    stim.delete();
    stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h02);
    for (int i = 0; i < 2048; i++) stim.push_back(8'($urandom));
    stim.push_back(8'hFF);
    run_stream("imem_full", 0);
    reset_dut("rst8");

    // Random multi-section frames, some ending in a bad target byte.
    for (int it = 0; it < 8; it++) begin
      stim.delete();
      nsec = int'($urandom_range(1, 4));
      for (int s = 0; s < nsec; s++) begin
        t = 8'($urandom_range(0, 1));
        n = int'($urandom_range(0, 5));
        stim.push_back(t);
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        for (int k = 0; k < 4 * n; k++) stim.push_back(8'($urandom));
      end
      if (it % 3 == 2) stim.push_back(8'($urandom_range(2, 254)));
      else             stim.push_back(8'hFF);
      run_stream("random", 35);
      reset_dut("rst_rand");
    end

    // Reset after two data bytes of the first word, then reload.
    qa.delete();
    qb.delete();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    chk("mid_busy", 32'(ifa.busy), 32'd1);
    reset_dut("rst_mid");
    chk("mid_no_wr_a", 32'(qa.size()), 32'd0);
    stim = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF};
    run_stream("reload", 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
